// File: rtl/fibonacci_seq_engine_if.sv
// Purpose: request/result bundle for the Fibonacci sequence engine.
// Latency: n/a (wires only).
// Backpressure: none; start is only sampled while the engine is idle (busy=0).
// Ports: start/n_in/stream_mode (requester -> engine); busy/done/fibo_out/overflow,
//        term_valid/term_data (engine -> requester).
interface fibonacci_seq_engine_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5
);
  logic              start;
  logic [IDX_W-1:0]  n_in;
  logic              stream_mode;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] fibo_out;
  logic              overflow;
  logic              term_valid;
  logic [DATA_W-1:0] term_data;

  modport master (
    output start, n_in, stream_mode,
    input  busy, done, fibo_out, overflow, term_valid, term_data
  );

  modport slave (
    input  start, n_in, stream_mode,
    output busy, done, fibo_out, overflow, term_valid, term_data
  );
endinterface

// File: rtl/fibonacci_seq_engine.sv
// Purpose: computes F(n) one iteration per clock, optionally streaming F(0)..F(n).
// Latency: n+1 clocks from start acceptance to the done pulse (n=0 -> 1 clock).
// Backpressure: none; start while busy is dropped, start during the done cycle is accepted.
// Ports: clk, reset_n (async active-low), bus (fibonacci_seq_engine_if.slave).
// Config: define FIBO_SATURATE_EN to clamp overflowed results/terms to all-ones;
//         otherwise overflowed values wrap modulo 2**DATA_W.
module fibonacci_seq_engine #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fibonacci_seq_engine_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  n_q, n_d;
  logic              stream_q, stream_d;
  logic [DATA_W-1:0] a_q, a_d;        // current term F(cnt)
  logic [DATA_W-1:0] b_q, b_d;        // look-ahead term F(cnt+1)
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              ovf_a_q, ovf_a_d; // F(cnt) has exceeded DATA_W bits
  logic              ovf_b_q, ovf_b_d; // F(cnt+1) has exceeded DATA_W bits
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] fibo_q, fibo_d;
  logic              overflow_q, overflow_d;
  logic              term_valid_q, term_valid_d;
  logic [DATA_W-1:0] term_data_q, term_data_d;

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] a_shown;         // F(cnt) as it should appear on the outputs

  assign sum = {1'b0, a_q} + {1'b0, b_q};

`ifdef FIBO_SATURATE_EN
  assign a_shown = ovf_a_q ? {DATA_W{1'b1}} : a_q;
`else
  assign a_shown = a_q;
`endif

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    stream_d     = stream_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    ovf_a_d      = ovf_a_q;
    ovf_b_d      = ovf_b_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    fibo_d       = fibo_q;
    overflow_d   = overflow_q;
    term_valid_d = 1'b0;
    term_data_d  = term_data_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d      = bus.n_in;
          stream_d = bus.stream_mode;
          a_d      = '0;
          b_d      = DATA_W'(1);
          cnt_d    = '0;
          ovf_a_d  = 1'b0;
          ovf_b_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (stream_q) begin
          term_valid_d = 1'b1;
          term_data_d  = a_shown;
        end
        // Terminate on equality before incrementing so cnt never wraps at max n.
        if (cnt_q == n_q) begin
          fibo_d     = a_shown;
          overflow_d = ovf_a_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          a_d     = b_q;
          b_d     = sum[DATA_W-1:0];
          // Overflow is sticky along the sequence: once a term overflows, all later ones do.
          ovf_a_d = ovf_b_q;
          ovf_b_d = ovf_a_q | ovf_b_q | sum[DATA_W];
          cnt_d   = cnt_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      n_q          <= '0;
      stream_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      ovf_a_q      <= 1'b0;
      ovf_b_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fibo_q       <= '0;
      overflow_q   <= 1'b0;
      term_valid_q <= 1'b0;
      term_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      stream_q     <= stream_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      ovf_a_q      <= ovf_a_d;
      ovf_b_q      <= ovf_b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fibo_q       <= fibo_d;
      overflow_q   <= overflow_d;
      term_valid_q <= term_valid_d;
      term_data_q  <= term_data_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.fibo_out   = fibo_q;
  assign bus.overflow   = overflow_q;
  assign bus.term_valid = term_valid_q;
  assign bus.term_data  = term_data_q;

endmodule

// File: tb/tb_fibonacci_seq_engine.sv
// Purpose: self-checking bench for fibonacci_seq_engine against an arithmetic Fibonacci model.
// Latency: checks n+1 clock latency and busy width per job.
// Backpressure: exercises ignored start while busy and back-to-back start in the done cycle.
module tb_fibonacci_seq_engine;
  localparam int DW = 16;
  localparam int IW = 5;

  logic clk;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  fibonacci_seq_engine_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

  fibonacci_seq_engine #(.DATA_W(DW), .IDX_W(IW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: true Fibonacci value in wide arithmetic.
  function automatic longint unsigned fib(input int k);
    longint unsigned x = 0;
    longint unsigned y = 1;
    longint unsigned t;
    for (int i = 0; i < k; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic bit fib_ovf(input int k);
    return fib(k) >= (64'd1 << DW);
  endfunction

  // Value the engine should present for F(k): wrapped, or clamped when saturation is built in.
  function automatic logic [DW-1:0] fib_shown(input int k);
    longint unsigned f;
    f = fib(k);
`ifdef FIBO_SATURATE_EN
    if (fib_ovf(k)) return {DW{1'b1}};
`endif
    return f[DW-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; leaves the bench #1 after the acceptance edge.
  task automatic start_job(input int n, input bit strm);
    bus.start       = 1'b1;
    bus.n_in        = IW'(n);
    bus.stream_mode = strm;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Runs from #1 after the acceptance edge up to the done cycle and checks the whole job.
  task automatic wait_done(input int n, input bit strm, input string tag);
    logic [DW-1:0] terms[$];
    int  edges    = 0;
    int  busy_cnt = 0;
    bit  seen     = 0;
    bit  tv_at_done = 0;
    if (bus.busy) busy_cnt++;
    while (!seen && edges < 64) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.busy) busy_cnt++;
      if (bus.term_valid) terms.push_back(bus.term_data);
      if (bus.done) begin
        seen       = 1;
        tv_at_done = bus.term_valid;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"},   32'(edges), 32'(n + 1));
    check({tag, "_busy_cyc"},  32'(busy_cnt), 32'(n + 1));
    check({tag, "_fibo"},      32'(bus.fibo_out), 32'(fib_shown(n)));
    check({tag, "_ovf"},       32'(bus.overflow), 32'(fib_ovf(n)));
    check({tag, "_nterms"},    32'(terms.size()), strm ? 32'(n + 1) : 32'd0);
    if (strm) begin
      check({tag, "_last_term_w_done"}, 32'(tv_at_done), 32'd1);
      for (int k = 0; k < terms.size() && k <= n; k++)
        check($sformatf("%s_term%0d", tag, k), 32'(terms[k]), 32'(fib_shown(k)));
    end
  endtask

  // One idle cycle: done/term_valid must have been single-cycle pulses and no job started.
  task automatic idle_cycle(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_tv_pulse"},   32'(bus.term_valid), 32'd0);
    check({tag, "_idle_busy"},  32'(bus.busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_fibo"}, 32'(bus.fibo_out), 32'd0);
    check({tag, "_ovf"},  32'(bus.overflow), 32'd0);
    check({tag, "_tv"},   32'(bus.term_valid), 32'd0);
    check({tag, "_td"},   32'(bus.term_data), 32'd0);
  endtask

  initial begin
    int  rn;
    bit  rs;
    reset_n         = 1'b0;
    bus.start       = 1'b0;
    bus.n_in        = '0;
    bus.stream_mode = 1'b0;

    // Reset state
    #12;
    check_outputs_zero("rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic indices and the n=0 corner
    start_job(0, 0);  wait_done(0, 0, "n0");   idle_cycle("n0");
    start_job(1, 0);  wait_done(1, 0, "n1");   idle_cycle("n1");
    start_job(10, 0); wait_done(10, 0, "n10"); idle_cycle("n10");

    // Stream mode
    start_job(6, 1);  wait_done(6, 1, "s6");   idle_cycle("s6");

    // Overflow boundary
    start_job(24, 0); wait_done(24, 0, "n24"); idle_cycle("n24");
    start_job(25, 1); wait_done(25, 1, "n25"); idle_cycle("n25");
    start_job(31, 0); wait_done(31, 0, "n31"); idle_cycle("n31");

    // Start held high while busy with different n/stream: must be ignored
    start_job(10, 0);
    bus.start       = 1'b1;
    bus.n_in        = IW'(3);
    bus.stream_mode = 1'b1;
    wait_done(10, 0, "ign");
    bus.start = 1'b0;
    idle_cycle("ign");

    // Back-to-back: new start presented during the done cycle
    start_job(4, 0);  wait_done(4, 0, "b2b_a");
    start_job(7, 1);
    check("b2b_no_gap_busy", 32'(bus.busy), 32'd1);
    wait_done(7, 1, "b2b_b");

    // Randomized jobs, chained with no idle gap
    for (int i = 0; i < 20; i++) begin
      rn = int'($urandom_range(0, 31));
      rs = 1'($urandom_range(0, 1));
      start_job(rn, rs);
      wait_done(rn, rs, $sformatf("rnd%0d_n%0d", i, rn));
    end
    idle_cycle("rnd");

    // Asynchronous reset in the middle of a long job
    start_job(20, 1);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    #3;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(posedge clk);
    #1;
    check_outputs_zero("midrst_hold");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle_busy", 32'(bus.busy), 32'd0);
    start_job(5, 0);  wait_done(5, 0, "post_rst_n5");
    idle_cycle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
